tri_det_seq: RTL and testbench

Sequential triangle-determinant unit for screen-space geometry. Accepts three vertices (A, B, C) one per handshake on a shared point bus and computes the signed determinant D = Ax·By + Bx·Cy + Cx·Ay − Ax·Cy − Bx·Ay − Cx·By. D is twice the signed triangle area. The unit uses one shared multiplier over six cycles and presents D with an orientation code on a valid/ready output. It sits between the vertex source and the rasterizer setup/culling stage.

---
 rtl/tri_det_seq_if.sv | 40 ++++
 rtl/tri_det_seq.sv | 192 +++++++++++++++++++
 tb/tb_tri_det_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/tri_det_seq_if.sv
// Vertex-in / determinant-out bus for tri_det_seq.
// Optional feature macro: TRI_DET_ABS_EN adds the det_abs signal.
interface tri_det_seq_if #(
  parameter int XW = 10,
  parameter int YW = 9
);
  localparam int DW = XW + YW + 3;

  logic                 in_valid;
  logic                 in_ready;
  logic [XW-1:0]        in_x;
  logic [YW-1:0]        in_y;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] det;
  logic [1:0]           orient;
`ifdef TRI_DET_ABS_EN
  logic [DW-2:0]        det_abs;
`endif

`ifdef TRI_DET_ABS_EN
  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, det, orient, det_abs
  );
  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, det, orient, det_abs
  );
`else
  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, det, orient
  );
  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, det, orient
  );
`endif
endinterface

// File: rtl/tri_det_seq.sv
// Sequential triangle determinant:
//   D = Ax*By + Bx*Cy + Cx*Ay - Ax*Cy - Bx*Ay - Cx*By
// Three vertices are taken one per handshake, then a single shared
// multiplier accumulates the six products over six cycles. The result
// is held on a valid/ready output with an orientation code
// (01 CCW, 10 CW, 00 degenerate).
// Optional feature macro: TRI_DET_ABS_EN adds a registered |D| output.
module tri_det_seq #(
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic         clk,
  input  logic         rst,
  tri_det_seq_if.slave bus
);
  localparam int PW = XW + YW;
  localparam int DW = PW + 3;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    LOAD_C,
    MUL,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [XW-1:0] ax_q, bx_q, cx_q;
  logic [YW-1:0] ay_q, by_q, cy_q;
  logic signed [DW-1:0] acc_q;
  logic signed [DW-1:0] det_q;
  logic [1:0]           orient_q;
  logic [2:0]           step_q;

  logic in_ready, out_valid;
  logic load_a, load_b, load_c, mul_en, last_step;

  logic [XW-1:0]        mul_x;
  logic [YW-1:0]        mul_y;
  logic                 mul_sub;
  logic [PW-1:0]        prod;
  logic signed [DW-1:0] prod_ext;
  logic signed [DW-1:0] sum_d;
  logic [1:0]           orient_d;

  assign last_step = (step_q == 3'd5);

  // State register; reset has priority over any handshake on the same edge.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD_A;
    else     state_q <= state_d;
  end

  // Next-state and handshake decode.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load_a    = 1'b0;
    load_b    = 1'b0;
    load_c    = 1'b0;
    mul_en    = 1'b0;
    unique case (state_q)
      LOAD_A: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          load_a  = 1'b1;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          load_b  = 1'b1;
          state_d = LOAD_C;
        end
      end
      LOAD_C: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          load_c  = 1'b1;
          state_d = MUL;
        end
      end
      MUL: begin
        mul_en = 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = LOAD_A;
      end
      default: state_d = LOAD_A;
    endcase
  end

  // Operand schedule for the shared multiplier: three positive then three
  // negative cross products.
  always_comb begin
    mul_x   = ax_q;
    mul_y   = by_q;
    mul_sub = 1'b0;
    case (step_q)
      3'd0: begin mul_x = ax_q; mul_y = by_q; end
      3'd1: begin mul_x = bx_q; mul_y = cy_q; end
      3'd2: begin mul_x = cx_q; mul_y = ay_q; end
      3'd3: begin mul_x = ax_q; mul_y = cy_q; mul_sub = 1'b1; end
      3'd4: begin mul_x = bx_q; mul_y = ay_q; mul_sub = 1'b1; end
      3'd5: begin mul_x = cx_q; mul_y = by_q; mul_sub = 1'b1; end
      default: ;
    endcase
  end

  // Unsigned product, zero-extended into the signed accumulator domain.
  assign prod     = {{YW{1'b0}}, mul_x} * {{XW{1'b0}}, mul_y};
  assign prod_ext = $signed({{(DW-PW){1'b0}}, prod});
  assign sum_d    = mul_sub ? (acc_q - prod_ext) : (acc_q + prod_ext);

  // Orientation of the running sum; only captured on the last step.
  always_comb begin
    if (sum_d == '0)       orient_d = 2'b00;
    else if (sum_d[DW-1])  orient_d = 2'b10;
    else                   orient_d = 2'b01;
  end

`ifdef TRI_DET_ABS_EN
  logic [DW-2:0] abs_d;
  logic [DW-2:0] det_abs_q;

  // |D| never reaches 2^(DW-2), so the top bit can be dropped safely.
  assign abs_d = sum_d[DW-1] ? (~sum_d[DW-2:0] + 1'b1) : sum_d[DW-2:0];

  // Magnitude register, written on the same edge as det.
  always_ff @(posedge clk) begin
    if (rst)                      det_abs_q <= '0;
    else if (mul_en && last_step) det_abs_q <= abs_d;
  end

  assign bus.det_abs = det_abs_q;
`endif

  // Vertex capture, accumulation and result registers.
  // NOTE: the vertex registers are reset too, so a restart can never expose
  // coordinates from a triangle that was abandoned mid-load.
  always_ff @(posedge clk) begin
    if (rst) begin
      ax_q     <= '0;
      ay_q     <= '0;
      bx_q     <= '0;
      by_q     <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      acc_q    <= '0;
      step_q   <= '0;
      det_q    <= '0;
      orient_q <= 2'b00;
    end else begin
      if (load_a) begin
        ax_q <= bus.in_x;
        ay_q <= bus.in_y;
      end
      if (load_b) begin
        bx_q <= bus.in_x;
        by_q <= bus.in_y;
      end
      if (load_c) begin
        cx_q   <= bus.in_x;
        cy_q   <= bus.in_y;
        acc_q  <= '0;
        step_q <= '0;
      end else if (mul_en) begin
        acc_q  <= sum_d;
        step_q <= step_q + 3'd1;
        if (last_step) begin
          det_q    <= sum_d;
          orient_q <= orient_d;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.det       = det_q;
  assign bus.orient    = orient_q;

endmodule

// File: tb/tb_tri_det_seq.sv
// Directed bench for tri_det_seq: hand-computed determinants, latency,
// backpressure and mid-load reset.
module tb_tri_det_seq;
  localparam int XW = 10;
  localparam int YW = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int passes = 0;

  tri_det_seq_if #(.XW(XW), .YW(YW)) bus ();

  tri_det_seq #(.XW(XW), .YW(YW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Offer one vertex from a falling edge; returns on the falling edge
  // after the accepting rising edge. in_valid is left high for chaining.
  task automatic send(input int x, input int y);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_x     = x[XW-1:0];
    bus.in_y     = y[YW-1:0];
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_on_send", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, bus.out_valid, 0);
    check({tag, "_in_ready_back"}, bus.in_ready, 1);
  endtask

  task automatic run_tri(input string tag,
                         input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy,
                         input logic signed [63:0] exp_det,
                         input logic [1:0] exp_or,
                         input logic [63:0] exp_abs,
                         input bit do_drain);
    int lat;
    send(ax, ay);
    send(bx, by);
    send(cx, cy);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 6);
    check({tag, "_det"}, bus.det, exp_det);
    check({tag, "_orient"}, bus.orient, exp_or);
`ifdef TRI_DET_ABS_EN
    check({tag, "_det_abs"}, bus.det_abs, exp_abs);
`else
    if (exp_abs > 64'd0) ;  // magnitude only observable with the option on
`endif
    if (do_drain) drain(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_det"}, bus.det, 0);
    check({tag, "_orient"}, bus.orient, 0);
`ifdef TRI_DET_ABS_EN
    check({tag, "_det_abs"}, bus.det_abs, 0);
`endif
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b0;

    // Power-on reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    // Right triangle, consumer always ready: 10*10 = 100, CCW.
    bus.out_ready = 1'b1;
    run_tri("ccw", 0, 0, 10, 0, 0, 10, 100, 2'b01, 100, 1'b1);
    bus.out_ready = 1'b0;

    // Same triangle with B and C swapped: -100 (0x3FFF9C), CW.
    run_tri("cw", 0, 0, 0, 10, 10, 0, -100, 2'b10, 100, 1'b1);

    // Colinear points: 2+6+3-3-2-6 = 0.
    run_tri("colinear", 1, 1, 2, 2, 3, 3, 0, 2'b00, 0, 1'b1);

    // Screen extremes: 639*479 = 306081; result left pending for backpressure.
    run_tri("extreme", 639, 0, 0, 479, 0, 0, 306081, 2'b01, 306081, 1'b0);

    // Backpressure: new points offered while the result is held.
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = 10'd7;
      bus.in_y     = 9'd7;
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_det_stable", bus.det, 306081);
      check("bp_orient_stable", bus.orient, 2'b01);
      check("bp_in_ready_low", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    drain("bp");

    // The offered (7,7) must not have become vertex A.
    run_tri("after_bp", 0, 0, 10, 0, 0, 10, 100, 2'b01, 100, 1'b1);

    // Full-range coordinates: only -Ax*Cy is non-zero: -1023*511 = -522753.
    run_tri("fullrange", 1023, 511, 0, 0, 0, 511, -522753, 2'b10, 522753, 1'b1);

    // Reset after B is accepted, with a vertex offered on the reset edge.
    send(5, 6);
    send(7, 8);
    bus.in_x = 10'd9;
    bus.in_y = 9'd9;
    rst      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check_reset_outputs("rst_edge");
    @(negedge clk);
    check_reset_outputs("rst_after");

    // Fresh triangle after reset: 4*4 = 16.
    run_tri("post_rst", 0, 0, 4, 0, 0, 4, 16, 2'b01, 16, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
